core2axi_mo: RTL and testbench

- Parametrised successor core-data-port-to-AXI4 master bridge.
- Accepts single-word (32-bit) core load/store requests on a req/gnt/rvalid interface and issues single-beat AXI4 transactions.
- Supports an AXI data bus wider than 32 bits via lane steering, up to MAX_OUTSTANDING in-flight transactions, and bus-error reporting to the core.
- Sits between the core data port and the AXI interconnect.

---
 rtl/core2axi_mo.sv | 277 +++++++++++++++++++++++++++
 tb/tb_core2axi_mo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core2axi_mo.sv
`timescale 1ns/1ps
// core2axi_mo: bridges a 32-bit core data port (req/gnt/rvalid) to single-beat
// AXI4 master transactions, with lane steering onto a wider AXI data bus and
// up to MAX_OUTSTANDING transactions in flight.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   data_*                  core side: request, grant, address/we/be/wdata,
//                           response pulse with rdata and error flag
//   aw_* / w_* / b_*        AXI write address, write data, write response
//   ar_* / r_*              AXI read address, read data/response
//
// Responses always return in request order: a request is only granted when it
// goes the same direction (read or write) as everything still in flight, so
// the single lane FIFO is enough to steer read data back to the core.
module core2axi_mo #(
  parameter int                        AXI_ADDR_WIDTH  = 32,
  parameter int                        AXI_DATA_WIDTH  = 64,
  parameter int                        AXI_ID_WIDTH    = 6,
  parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID          = '0,
  parameter int                        MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // core data port
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [3:0]                  data_be_i,
  input  logic [31:0]                 data_wdata_i,
  output logic [31:0]                 data_rdata_o,
  output logic                        data_err_o,
  // AXI write address
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [7:0]                  aw_len_o,
  output logic [2:0]                  aw_size_o,
  output logic [1:0]                  aw_burst_o,
  output logic                        aw_lock_o,
  output logic [3:0]                  aw_cache_o,
  output logic [2:0]                  aw_prot_o,
  output logic [3:0]                  aw_region_o,
  output logic [3:0]                  aw_qos_o,
  output logic                        aw_user_o,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  // AXI write data
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  output logic                        w_user_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  // AXI write response
  input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
  input  logic [1:0]                  b_resp_i,
  input  logic                        b_valid_i,
  input  logic                        b_user_i,
  output logic                        b_ready_o,
  // AXI read address
  output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [7:0]                  ar_len_o,
  output logic [2:0]                  ar_size_o,
  output logic [1:0]                  ar_burst_o,
  output logic                        ar_lock_o,
  output logic [3:0]                  ar_cache_o,
  output logic [2:0]                  ar_prot_o,
  output logic [3:0]                  ar_region_o,
  output logic [3:0]                  ar_qos_o,
  output logic                        ar_user_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  // AXI read data
  input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_last_i,
  input  logic                        r_user_i,
  input  logic                        r_valid_i,
  output logic                        r_ready_o
);

  localparam int NUM_LANES = AXI_DATA_WIDTH / 32;
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int STRB_W    = AXI_DATA_WIDTH / 8;
  localparam int PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);

  if (!(AXI_DATA_WIDTH == 32 || AXI_DATA_WIDTH == 64 ||
        AXI_DATA_WIDTH == 128 || AXI_DATA_WIDTH == 256)) begin : g_bad_dw
    $error("core2axi_mo: unsupported AXI_DATA_WIDTH %0d", AXI_DATA_WIDTH);
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16 ||
      (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_mo
    $error("core2axi_mo: unsupported MAX_OUTSTANDING %0d", MAX_OUTSTANDING);
  end

  // ---------------------------------------------------------------- state
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      dir_q;          // 1 = writes in flight
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0]         lane_mem [MAX_OUTSTANDING];

  logic                      aw_valid_q, w_valid_q, ar_valid_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;

  logic                      rvalid_q, err_q;
  logic [31:0]               rdata_q;

  // ---------------------------------------------------------------- request side
  logic [LANE_W-1:0]         req_lane;
  logic [AXI_DATA_WIDTH-1:0] wdata_rep;
  logic [AXI_ADDR_WIDTH-1:0] req_addr_aligned;

  if (NUM_LANES > 1) begin : g_lane_n
    assign req_lane = data_addr_i[LANE_W+1:2];
  end else begin : g_lane_1
    assign req_lane = '0;
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_wrep
    assign wdata_rep[32*gi +: 32] = data_wdata_i;
  end

  assign req_addr_aligned = {data_addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};

  // ---------------------------------------------------------------- response side
  logic              resp_valid, resp_fire, gnt;
  logic [1:0]        resp_code;
  logic [LANE_W-1:0] head_lane;
  logic [31:0]       r_word;

  assign head_lane  = lane_mem[rd_ptr_q];
  assign resp_valid = dir_q ? b_valid_i : r_valid_i;
  assign resp_code  = dir_q ? b_resp_i : r_resp_i;
  // Beats arriving with nothing in flight are swallowed (ready is high) but
  // never reach the core and never touch the counter.
  assign resp_fire  = !rst_i && resp_valid && (cnt_q != '0);

  if (NUM_LANES > 1) begin : g_rsel_n
    logic [31:0] r_lanes [NUM_LANES];
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_rlane
      assign r_lanes[gi] = r_data_i[32*gi +: 32];
    end
    assign r_word = r_lanes[head_lane];
  end else begin : g_rsel_1
    assign r_word = r_data_i;
  end

  // ---------------------------------------------------------------- grant
  logic aw_free, w_free, ar_free, slot_free, dir_ok;

  // A slot whose handshake completes this cycle can be reloaded at the same edge.
  assign aw_free   = !aw_valid_q || aw_ready_i;
  assign w_free    = !w_valid_q  || w_ready_i;
  assign ar_free   = !ar_valid_q || ar_ready_i;
  assign slot_free = data_we_i ? (aw_free && w_free) : ar_free;
  // Direction may flip when the last in-flight response retires this cycle.
  assign dir_ok    = (cnt_q == '0) || (dir_q == data_we_i) ||
                     ((cnt_q == CNT_W'(1)) && resp_fire);
  assign gnt       = !rst_i && data_req_i && (cnt_q < CNT_W'(MAX_OUTSTANDING)) &&
                     dir_ok && slot_free;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (gnt && !resp_fire)      cnt_d = cnt_q + 1'b1;
    else if (!gnt && resp_fire) cnt_d = cnt_q - 1'b1;
    if (gnt)       wr_ptr_d = ptr_inc(wr_ptr_q);
    if (resp_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (gnt) dir_q <= data_we_i;

      if (gnt && data_we_i) begin
        aw_valid_q <= 1'b1;
        w_valid_q  <= 1'b1;
      end else begin
        if (aw_ready_i) aw_valid_q <= 1'b0;
        if (w_ready_i)  w_valid_q  <= 1'b0;
      end
      if (gnt && !data_we_i)   ar_valid_q <= 1'b1;
      else if (ar_ready_i)     ar_valid_q <= 1'b0;

      rvalid_q <= resp_fire;
      err_q    <= resp_fire && resp_code[1];
      if (resp_fire && !dir_q) rdata_q <= r_word;
    end
  end

  // Payload and lane storage need no reset: qualified by the valids/counter.
  always_ff @(posedge clk_i) begin
    if (gnt) begin
      lane_mem[wr_ptr_q] <= req_lane;
      if (data_we_i) begin
        aw_addr_q <= req_addr_aligned;
        w_data_q  <= wdata_rep;
        w_strb_q  <= STRB_W'(data_be_i) << {req_lane, 2'b00};
      end else begin
        ar_addr_q <= req_addr_aligned;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

  assign aw_id_o     = AXI_ID;
  assign aw_addr_o   = aw_addr_q;
  assign aw_len_o    = 8'd0;
  assign aw_size_o   = 3'b010;
  assign aw_burst_o  = 2'b01;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = 4'd0;
  assign aw_prot_o   = 3'd0;
  assign aw_region_o = 4'd0;
  assign aw_qos_o    = 4'd0;
  assign aw_user_o   = 1'b0;
  assign aw_valid_o  = aw_valid_q;

  assign w_data_o  = w_data_q;
  assign w_strb_o  = w_strb_q;
  assign w_last_o  = 1'b1;
  assign w_user_o  = 1'b0;
  assign w_valid_o = w_valid_q;

  assign ar_id_o     = AXI_ID;
  assign ar_addr_o   = ar_addr_q;
  assign ar_len_o    = 8'd0;
  assign ar_size_o   = 3'b010;
  assign ar_burst_o  = 2'b01;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = 4'd0;
  assign ar_prot_o   = 3'd0;
  assign ar_region_o = 4'd0;
  assign ar_qos_o    = 4'd0;
  assign ar_user_o   = 1'b0;
  assign ar_valid_o  = ar_valid_q;

  assign b_ready_o = !rst_i;
  assign r_ready_o = !rst_i;

  // Inputs carried by the protocol but meaningless for single-beat, single-ID use.
  logic unused_inputs;
  assign unused_inputs = ^{b_id_i, b_user_i, r_id_i, r_user_i, r_last_i,
                           b_resp_i[0], r_resp_i[0], data_addr_i[1:0]};

endmodule

// File: tb/tb_core2axi_mo.sv
`timescale 1ns/1ps
module tb_core2axi_mo;
  localparam int AW = 32, DW = 64, IDW = 6, MAXO = 4;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [AW-1:0]   data_addr_i;
  logic [3:0]      data_be_i;
  logic [31:0]     data_wdata_i, data_rdata_o;
  logic [IDW-1:0]  aw_id_o, ar_id_o, b_id_i, r_id_i;
  logic [AW-1:0]   aw_addr_o, ar_addr_o;
  logic [7:0]      aw_len_o, ar_len_o;
  logic [2:0]      aw_size_o, ar_size_o, aw_prot_o, ar_prot_o;
  logic [1:0]      aw_burst_o, ar_burst_o, b_resp_i, r_resp_i;
  logic [3:0]      aw_cache_o, ar_cache_o, aw_region_o, ar_region_o, aw_qos_o, ar_qos_o;
  logic            aw_lock_o, ar_lock_o, aw_user_o, ar_user_o, w_user_o, w_last_o;
  logic            aw_valid_o, aw_ready_i, ar_valid_o, ar_ready_i, w_valid_o, w_ready_i;
  logic [DW-1:0]   w_data_o, r_data_i;
  logic [DW/8-1:0] w_strb_o;
  logic            b_valid_i, b_user_i, b_ready_o, r_valid_i, r_user_i, r_last_i, r_ready_o;

  core2axi_mo #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW),
                .AXI_ID('0), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
    .aw_burst_o(aw_burst_o), .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o),
    .aw_prot_o(aw_prot_o), .aw_region_o(aw_region_o), .aw_qos_o(aw_qos_o),
    .aw_user_o(aw_user_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_user_i(b_user_i),
    .b_ready_o(b_ready_o),
    .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .ar_burst_o(ar_burst_o), .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o),
    .ar_prot_o(ar_prot_o), .ar_region_o(ar_region_o), .ar_qos_o(ar_qos_o),
    .ar_user_o(ar_user_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i),
    .r_user_i(r_user_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
  );

  int n_checks = 0, n_fail = 0;
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model: word-addressed memory + error-region rule
  function automatic logic [31:0] def_word(input logic [31:0] waddr);
    return (waddr * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  // Address bits [6:5] pick the slave's response: OKAY, SLVERR, DECERR, EXOKAY.
  function automatic logic [1:0] resp_for(input logic [31:0] a);
    logic [1:0] sel;
    sel = a[6:5];
    case (sel)
      2'd0: return 2'b00;
      2'd1: return 2'b10;
      2'd2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  logic [31:0] mdl_mem [int unsigned];
  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    int unsigned k = a >> 2;
    return mdl_mem.exists(k) ? mdl_mem[k] : def_word(k);
  endfunction

  typedef struct { bit we; logic [31:0] rdata; bit err; } exp_t;
  exp_t          exp_q [$];
  logic [31:0]   exp_ar [$], exp_aw [$];
  logic [DW-1:0] exp_wd [$];
  logic [7:0]    exp_ws [$];
  int gnt_cnt = 0, rv_cnt = 0, gnt_cyc = -1, r_hs_cyc = -2;

  function automatic void on_grant(input bit we, input logic [31:0] a,
                                   input logic [3:0] be, input logic [31:0] wd);
    exp_t e; logic [31:0] w; logic [1:0] rc; logic [7:0] be8;
    rc = resp_for(a);
    e.we = we; e.err = rc[1]; e.rdata = '0;
    if (we) begin
      w = mdl_rd(a);
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      mdl_mem[a >> 2] = w;
      be8 = {4'b0, be};
      exp_aw.push_back({a[31:2], 2'b00});
      exp_wd.push_back({wd, wd});
      exp_ws.push_back(a[2] ? (be8 << 4) : be8);
    end else begin
      e.rdata = mdl_rd(a);
      exp_ar.push_back({a[31:2], 2'b00});
    end
    exp_q.push_back(e);
    gnt_cnt++;
    gnt_cyc = cyc;
  endfunction

  // ---------------- slave model: 64-bit memory, in-order responses
  typedef struct { bit we; logic [63:0] data; logic [1:0] resp; } sresp_t;
  sresp_t      s_pend [$];
  logic [31:0] s_awq [$];
  logic [63:0] s_wdq [$];
  logic [7:0]  s_wsq [$];
  logic [63:0] s_mem [int unsigned];
  bit hold_resp = 0;

  function automatic logic [63:0] s_rd(input int unsigned idx);
    return s_mem.exists(idx) ? s_mem[idx] : {def_word(idx*2+1), def_word(idx*2)};
  endfunction

  initial begin : slave
    sresp_t s; bit busy = 0, hs = 0;
    logic [31:0] a; logic [63:0] d, cur; logic [7:0] st;
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    b_valid_i = 0; r_valid_i = 0; b_resp_i = 0; r_resp_i = 0; r_data_i = '0;
    b_id_i = '0; r_id_i = '0; b_user_i = 0; r_user_i = 0; r_last_i = 1;
    forever begin
      @(negedge clk);
      if (hs) begin
        r_valid_i = 0; b_valid_i = 0; s = s_pend.pop_front(); hs = 0; busy = 0;
      end
      aw_ready_i = ($urandom_range(0, 3) != 0);
      w_ready_i  = ($urandom_range(0, 3) != 0);
      ar_ready_i = ($urandom_range(0, 3) != 0);
      if (!busy && s_pend.size() > 0 && !hold_resp && $urandom_range(0, 2) != 0) begin
        s = s_pend[0]; busy = 1;
        if (s.we) begin b_valid_i = 1; b_resp_i = s.resp; b_id_i = IDW'($urandom); end
        else begin r_valid_i = 1; r_resp_i = s.resp; r_data_i = s.data; end
      end
      #4;
      if (aw_valid_o && aw_ready_i) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else check("aw_addr", aw_addr_o, exp_aw.pop_front());
        s_awq.push_back(aw_addr_o);
      end
      if (w_valid_o && w_ready_i) begin
        if (exp_wd.size() == 0) check("w_unexpected", 1, 0);
        else begin
          check("w_data", w_data_o, exp_wd.pop_front());
          check("w_strb", w_strb_o, exp_ws.pop_front());
        end
        s_wdq.push_back(w_data_o); s_wsq.push_back(w_strb_o);
      end
      if (ar_valid_o && ar_ready_i) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
        else check("ar_addr", ar_addr_o, exp_ar.pop_front());
        s_pend.push_back('{we: 0, data: s_rd(ar_addr_o >> 3), resp: resp_for(ar_addr_o)});
      end
      while (s_awq.size() > 0 && s_wdq.size() > 0) begin
        a = s_awq.pop_front(); d = s_wdq.pop_front(); st = s_wsq.pop_front();
        cur = s_rd(a >> 3);
        for (int i = 0; i < 8; i++) if (st[i]) cur[8*i +: 8] = d[8*i +: 8];
        s_mem[a >> 3] = cur;
        s_pend.push_back('{we: 1, data: 64'h0, resp: resp_for(a)});
      end
      if (busy && ((r_valid_i && r_ready_o) || (b_valid_i && b_ready_o))) begin
        hs = 1;
        if (r_valid_i) r_hs_cyc = cyc;
      end
    end
  end

  // ---------------- scoreboard monitor
  initial begin : scoreboard
    exp_t e; logic [31:0] last_load = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) last_load = '0;
      else if (data_rvalid_o) begin
        rv_cnt++;
        if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (!e.we) last_load = e.rdata;
          check("rsp_err", data_err_o, e.err);
          check(e.we ? "wr_rdata_hold" : "rd_data", data_rdata_o, last_load);
          $display("rsp cyc=%0d we=%0d rdata=%h err=%0d", cyc, e.we, data_rdata_o, data_err_o);
        end
      end
    end
  end

  // ---------------- core-side driver
  task automatic do_req(input bit we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    int waited = 0;
    @(negedge clk);
    data_req_i = 1; data_we_i = we; data_addr_i = a; data_be_i = be; data_wdata_i = wd;
    forever begin
      #4;
      if (data_gnt_o) begin on_grant(we, a, be, wd); break; end
      if (++waited > 300) begin check("gnt_timeout", 0, 1); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    data_req_i = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  int g0, rv0;
  initial begin : main
    rst = 1; data_req_i = 1; data_we_i = 0; data_addr_i = 32'h1000; data_be_i = 4'hF;
    data_wdata_i = '0;
    repeat (3) @(negedge clk);
    #4;
    check("rst_gnt", data_gnt_o, 0);
    check("rst_rvalid", data_rvalid_o, 0);
    check("rst_err", data_err_o, 0);
    check("rst_rdata", data_rdata_o, 0);
    check("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o}, 0);
    check("rst_readies", {b_ready_o, r_ready_o}, 0);
    @(negedge clk);
    data_req_i = 0; rst = 0;
    #4;
    check("readies_after_rst", {b_ready_o, r_ready_o}, 2'b11);
    check("ar_fixed", {ar_len_o, ar_size_o, ar_burst_o, ar_id_o}, {8'd0, 3'b010, 2'b01, 6'd0});
    check("aw_fixed", {aw_len_o, aw_size_o, aw_burst_o, w_last_o}, {8'd0, 3'b010, 2'b01, 1'b1});

    // Directed load: upper lane of a 64-bit word.
    s_mem[32'h1004 >> 3] = 64'hAAAA_BBBB_1111_2222;
    mdl_mem[32'h1004 >> 2] = 32'hAAAA_BBBB;
    mdl_mem[32'h1000 >> 2] = 32'h1111_2222;
    do_req(0, 32'h1004, 4'hF, 0);
    wait_idle();
    // Directed store: upper lane, low half-word.
    do_req(1, 32'h2004, 4'b0011, 32'hDEAD_BEEF);
    wait_idle();

    // Outstanding limit with responses held back.
    hold_resp = 1; g0 = gnt_cnt; rv0 = rv_cnt;
    fork
      for (int i = 0; i < 6; i++) do_req(0, 32'h4000 + 32'(8*i + 4*(i%2)), 4'hF, 0);
      begin
        repeat (25) @(negedge clk);
        #4;
        check("os_limit_grants", gnt_cnt - g0, MAXO);
        check("os_req_stalled", data_req_i, 1);
        hold_resp = 0;
      end
    join
    wait_idle();
    check("os_rvalid_count", rv_cnt - rv0, 6);

    // Store behind an outstanding load: granted exactly with the R handshake.
    hold_resp = 1; g0 = gnt_cnt;
    fork
      begin do_req(0, 32'h5008, 4'hF, 0); do_req(1, 32'h5008, 4'b1001, 32'h1234_5678); end
      begin
        repeat (15) @(negedge clk);
        check("dir_block", gnt_cnt - g0, 1);
        hold_resp = 0;
      end
    join
    check("dir_switch_cycle", gnt_cyc, r_hs_cyc);
    wait_idle();

    // Error response then OKAY.
    do_req(1, 32'h2024, 4'hF, 32'hCAFE_F00D);
    do_req(0, 32'h2004, 4'hF, 0);
    wait_idle();

    // Reset with two loads in flight, then stale R beats.
    hold_resp = 1;
    do_req(0, 32'h6000, 4'hF, 0);
    do_req(0, 32'h6004, 4'hF, 0);
    repeat (10) @(negedge clk);
    rst = 1;
    exp_q.delete(); exp_ar.delete(); exp_aw.delete(); exp_wd.delete(); exp_ws.delete();
    repeat (2) @(negedge clk);
    rst = 0; rv0 = rv_cnt; hold_resp = 0;
    repeat (20) @(negedge clk);
    check("stale_rvalid", rv_cnt - rv0, 0);
    check("stale_consumed", s_pend.size(), 0);
    do_req(0, 32'h1004, 4'hF, 0);
    do_req(0, 32'h1000, 4'hF, 0);
    wait_idle();

    // Randomized mix of loads and stores over a small window with error regions.
    for (int n = 0; n < 300; n++) begin
      do_req($urandom_range(0, 1) == 1, 32'h3000 + 32'(4 * $urandom_range(0, 31)),
             4'($urandom_range(1, 15)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    check("end_exp_empty", exp_q.size() + exp_ar.size() + exp_aw.size() + exp_wd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
